// File: rtl/sp_ram_req_ctrl_pkg.sv
// Shared definitions for the single-port RAM request controller:
// FSM state encoding, legal RAM read latencies and the all-ones strobe test.
package sp_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RMW_WAIT = 2'd2,
        ST_RSP      = 2'd3
    } state_e;

    localparam int LAT_LOW_LATENCY  = 1;
    localparam int LAT_HIGH_PERF    = 2;
    localparam int MAX_BE_W         = 64;

    // Only the low be_w bits of the zero-extended strobe vector are examined.
    function automatic logic full_be(input logic [MAX_BE_W-1:0] be, input int be_w);
        logic all_set;
        all_set = 1'b1;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if ((i < be_w) && !be[i]) all_set = 1'b0;
        end
        return all_set;
    endfunction

endpackage

// File: rtl/sp_ram_req_ctrl_if.sv
// Request/response bus between the core load/store path (master)
// and the RAM request controller (slave).
interface sp_ram_req_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W/8-1:0]   req_be;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sp_ram_req_ctrl_be_merge.sv
// Per-byte merge of new write data over the word read back from RAM.
module be_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W-1:0]   old_i,
    output logic [DATA_W-1:0]   merged_o
);
    for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte
        assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end
endmodule

// File: rtl/sp_ram_req_ctrl.sv
// Valid/ready request bus to single-port BRAM port initiator, with read-latency
// tracking and read-modify-write for partial byte-strobed writes.
module sp_ram_req_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_ram_req_ctrl_if.slave  bus,
    output logic              ram_ena_o,
    output logic              ram_wea_o,
    output logic [ADDR_W-1:0] ram_addra_o,
    output logic [DATA_W-1:0] ram_dina_o,
    output logic              ram_regcea_o,
    output logic              ram_rsta_o,
    input  logic [DATA_W-1:0] ram_douta_i
);
    localparam int BE_W = DATA_W / 8;

    if (!((RAM_LATENCY == LAT_LOW_LATENCY) || (RAM_LATENCY == LAT_HIGH_PERF))) begin : g_bad_latency
        $error("sp_ram_req_ctrl: RAM_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("sp_ram_req_ctrl: DATA_W must be a multiple of 8");
    end

    state_e            state_q;
    logic              cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              regcea_q;

    logic              req_ready;
    logic              accept;
    logic              req_full;
    logic              req_none;
    logic              wait_done;
    logic [DATA_W-1:0] merged;

    assign req_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_RSP) & bus.rsp_ready));
    assign accept    = req_ready & bus.req_valid;
    assign req_full  = full_be(MAX_BE_W'(bus.req_be), BE_W);
    assign req_none  = ~|bus.req_be;
    assign wait_done = (cnt_q == 1'(RAM_LATENCY - 1));

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign ram_rsta_o   = ~rst_n;
    assign ram_regcea_o = (RAM_LATENCY == LAT_HIGH_PERF) ? regcea_q : 1'b0;

    be_merge #(.DATA_W(DATA_W)) u_be_merge (
        .be_i     (be_q),
        .new_i    (wdata_q),
        .old_i    (ram_douta_i),
        .merged_o (merged)
    );

    // Request-side RAM cycles come straight from the bus; the RMW write phase from latched state.
    always_comb begin
        ram_ena_o   = 1'b0;
        ram_wea_o   = 1'b0;
        ram_addra_o = bus.req_addr;
        ram_dina_o  = bus.req_wdata;
        if (accept) begin
            if (!bus.req_we) begin
                ram_ena_o = 1'b1;
            end else if (req_full) begin
                ram_ena_o = 1'b1;
                ram_wea_o = 1'b1;
            end else if (!req_none) begin
                ram_ena_o = 1'b1;
            end
        end else if ((state_q == ST_RMW_WAIT) && wait_done) begin
            ram_ena_o   = 1'b1;
            ram_wea_o   = 1'b1;
            ram_addra_o = addr_q;
            ram_dina_o  = merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            regcea_q    <= 1'b0;
        end else begin
            regcea_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RSP: begin
                    if (accept) begin
                        cnt_q <= 1'b0;
                        if (!bus.req_we) begin
                            state_q     <= ST_RD_WAIT;
                            rsp_valid_q <= 1'b0;
                            regcea_q    <= 1'b1;
                        end else if (req_full || req_none) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_RMW_WAIT;
                            rsp_valid_q <= 1'b0;
                            regcea_q    <= 1'b1;
                            addr_q      <= bus.req_addr;
                            be_q        <= bus.req_be;
                            wdata_q     <= bus.req_wdata;
                        end
                    end else if ((state_q == ST_RSP) && bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_done) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ram_douta_i;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RMW_WAIT: begin
                    if (wait_done) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Drives one controller built for a LOW_LATENCY RAM and one for a HIGH_PERFORMANCE RAM,
// each attached to a behavioural BRAM, and compares against a word-level memory model.
module tb_sp_ram_req_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    logic memClear;

    logic          reqValid  [2];
    logic          reqWe     [2];
    logic [AW-1:0] reqAddr   [2];
    logic [BW-1:0] reqBe     [2];
    logic [DW-1:0] reqWdata  [2];
    logic          rspReady  [2];
    logic          reqReady  [2];
    logic          rspValid  [2];
    logic [DW-1:0] rspRdata  [2];
    logic          ramEna    [2];
    logic          ramWea    [2];
    logic [AW-1:0] ramAddra  [2];
    logic [DW-1:0] ramDina   [2];
    logic          ramRegcea [2];
    logic          ramRsta   [2];
    logic [DW-1:0] ramDouta  [2];

    logic [DW-1:0] refMem [2][DEPTH];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance g is built for RAM_LATENCY = g+1, with its own BRAM model.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        sp_ram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.req_valid = reqValid[g];
        assign bus.req_we    = reqWe[g];
        assign bus.req_addr  = reqAddr[g];
        assign bus.req_be    = reqBe[g];
        assign bus.req_wdata = reqWdata[g];
        assign bus.rsp_ready = rspReady[g];
        assign reqReady[g]   = bus.req_ready;
        assign rspValid[g]   = bus.rsp_valid;
        assign rspRdata[g]   = bus.rsp_rdata;

        sp_ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(g + 1)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .bus          (bus),
            .ram_ena_o    (ramEna[g]),
            .ram_wea_o    (ramWea[g]),
            .ram_addra_o  (ramAddra[g]),
            .ram_dina_o   (ramDina[g]),
            .ram_regcea_o (ramRegcea[g]),
            .ram_rsta_o   (ramRsta[g]),
            .ram_douta_i  (ramDouta[g])
        );

        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] latchQ;
        logic [DW-1:0] outRegQ;

        always @(posedge clk) begin
            if (memClear) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                latchQ <= '0;
            end else if (ramEna[g]) begin
                if (ramWea[g]) mem[ramAddra[g]] <= ramDina[g];
                else           latchQ <= mem[ramAddra[g]];
            end
            if (ramRsta[g] || memClear) outRegQ <= '0;
            else if (ramRegcea[g])      outRegQ <= latchQ;
        end

        assign ramDouta[g] = (g == 0) ? latchQ : outRegQ;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic logic [DW-1:0] modelMerge(input logic [DW-1:0] oldW, input logic [DW-1:0] newW,
                                                 input logic [BW-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < BW; i++) if (be[i]) mask = mask | (DW'(32'hFF) << (8 * i));
        return (oldW & ~mask) | (newW & mask);
    endfunction

    function automatic int expLat(input int d, input logic we, input logic [BW-1:0] be);
        if (!we) return d + 2;
        if (be == '1 || be == '0) return 1;
        return d + 2;
    endfunction

    function automatic int expEna(input logic we, input logic [BW-1:0] be);
        if (!we) return 1;
        if (be == '1) return 1;
        if (be == '0) return 0;
        return 2;
    endfunction

    // One request with rspReady held high; reports latency, data and RAM activity seen.
    task automatic doReq(input int d, input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                         input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rdata,
                         output int enaCnt, output int weaCnt);
        bit accepted;
        lat = -1; rdata = '0; enaCnt = 0; weaCnt = 0; accepted = 0;
        @(posedge clk); #1;
        reqValid[d] = 1'b1; reqWe[d] = we; reqAddr[d] = addr; reqBe[d] = be;
        reqWdata[d] = wdata; rspReady[d] = 1'b1;
        #1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            if (reqReady[d]) accepted = 1;
            else begin @(posedge clk); #2; end
        end
        if (!accepted) begin reqValid[d] = 1'b0; return; end
        if (ramEna[d]) enaCnt++;
        if (ramEna[d] && ramWea[d]) weaCnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            reqValid[d] = 1'b0;
            #1;
            if (ramEna[d]) enaCnt++;
            if (ramEna[d] && ramWea[d]) weaCnt++;
            if (rspValid[d]) begin lat = k; rdata = rspRdata[d]; break; end
        end
        if (we && lat >= 0) refMem[d][addr] = modelMerge(refMem[d][addr], wdata, be);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; memClear = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++; if (reqReady[d] !== 1'b0) begin bad++; $display("FAIL reset_req_ready[%0d] actual=%b required=0", d, reqReady[d]); end
            total++; if (rspValid[d] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid[%0d] actual=%b required=0", d, rspValid[d]); end
            total++; if (rspRdata[d] !== '0) begin bad++; $display("FAIL reset_rsp_rdata[%0d] actual=%h required=0", d, rspRdata[d]); end
            total++; if (ramEna[d] !== 1'b0 || ramRegcea[d] !== 1'b0) begin bad++; $display("FAIL reset_ram_ctrl[%0d] actual=ena%b regce%b required=0", d, ramEna[d], ramRegcea[d]); end
            total++; if (ramRsta[d] !== 1'b1) begin bad++; $display("FAIL reset_rsta[%0d] actual=%b required=1", d, ramRsta[d]); end
        end
        repeat (2) @(posedge clk);
        #1; memClear = 1'b0; rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++; if (reqReady[d] !== 1'b1) begin bad++; $display("FAIL idle_req_ready[%0d] actual=%b required=1", d, reqReady[d]); end
            total++; if (ramRsta[d] !== 1'b0) begin bad++; $display("FAIL idle_rsta[%0d] actual=%b required=0", d, ramRsta[d]); end
        end
    endtask

    task automatic test_read_after_reset(input int d);
        int lat, ec, wc; logic [DW-1:0] rd;
        doReq(d, 1'b0, AW'(10'h005), '0, '0, lat, rd, ec, wc);
        total++; if (lat != d + 2) begin bad++; $display("FAIL first_read_latency[%0d] actual=%0d required=%0d", d, lat, d + 2); end
        total++; if (rd !== '0) begin bad++; $display("FAIL first_read_data[%0d] actual=%h required=0", d, rd); end
    endtask

    task automatic test_full_write(input int d);
        int lat, ec, wc; logic [DW-1:0] rd;
        doReq(d, 1'b1, AW'(10'h010), '1, 32'hDEADBEEF, lat, rd, ec, wc);
        total++; if (lat != 1) begin bad++; $display("FAIL full_write_latency[%0d] actual=%0d required=1", d, lat); end
        total++; if (ec != 1 || wc != 1) begin bad++; $display("FAIL full_write_ram[%0d] actual=ena%0d/wea%0d required=1/1", d, ec, wc); end
        doReq(d, 1'b0, AW'(10'h010), '0, '0, lat, rd, ec, wc);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL full_write_readback[%0d] actual=%h required=deadbeef", d, rd); end
    endtask

    task automatic test_partial_write(input int d);
        int lat, ec, wc; logic [DW-1:0] rd;
        doReq(d, 1'b1, AW'(10'h020), '1, 32'h11223344, lat, rd, ec, wc);
        doReq(d, 1'b1, AW'(10'h020), 4'b0101, 32'hAABBCCDD, lat, rd, ec, wc);
        total++; if (lat != d + 2) begin bad++; $display("FAIL rmw_latency[%0d] actual=%0d required=%0d", d, lat, d + 2); end
        total++; if (ec != 2 || wc != 1) begin bad++; $display("FAIL rmw_ram[%0d] actual=ena%0d/wea%0d required=2/1", d, ec, wc); end
        total++; if (rd !== '0) begin bad++; $display("FAIL rmw_rsp_data[%0d] actual=%h required=0", d, rd); end
        doReq(d, 1'b0, AW'(10'h020), '0, '0, lat, rd, ec, wc);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL rmw_readback[%0d] actual=%h required=11bb33dd", d, rd); end
        doReq(d, 1'b1, AW'(10'h020), '0, 32'h55555555, lat, rd, ec, wc);
        total++; if (lat != 1 || ec != 0) begin bad++; $display("FAIL be0_write[%0d] actual=lat%0d/ena%0d required=1/0", d, lat, ec); end
        doReq(d, 1'b0, AW'(10'h020), '0, '0, lat, rd, ec, wc);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be0_readback[%0d] actual=%h required=11bb33dd", d, rd); end
    endtask

    task automatic test_backpressure(input int d);
        logic [DW-1:0] expData;
        bit seen;
        expData = refMem[d][10'h010];
        seen = 0;
        @(posedge clk); #1;
        reqValid[d] = 1'b1; reqWe[d] = 1'b0; reqAddr[d] = AW'(10'h010); rspReady[d] = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            reqValid[d] = 1'b0;
            #1;
            if (rspValid[d]) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_rsp_timeout[%0d] actual=none required=rsp_valid", d); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            reqValid[d] = 1'b1; reqAddr[d] = AW'(10'h123);
            #1;
            total++; if (rspValid[d] !== 1'b1 || rspRdata[d] !== expData) begin bad++; $display("FAIL bp_hold[%0d] actual=v%b/%h required=v1/%h", d, rspValid[d], rspRdata[d], expData); end
            total++; if (reqReady[d] !== 1'b0 || ramEna[d] !== 1'b0) begin bad++; $display("FAIL bp_quiet[%0d] actual=rdy%b/ena%b required=0/0", d, reqReady[d], ramEna[d]); end
        end
        @(posedge clk); #1;
        reqValid[d] = 1'b0; rspReady[d] = 1'b1;
        @(posedge clk); #2;
        total++; if (rspValid[d] !== 1'b0 || reqReady[d] !== 1'b1) begin bad++; $display("FAIL bp_release[%0d] actual=v%b/rdy%b required=v0/rdy1", d, rspValid[d], reqReady[d]); end
    endtask

    task automatic test_back_to_back(input int d);
        int lat, ec, wc, idx, nRsp, cyc;
        logic [DW-1:0] rd, expD;
        int enaCyc[$];
        logic [DW-1:0] expQ[$];
        for (int i = 0; i < 4; i++) doReq(d, 1'b1, AW'(10'h040 + i), '1, $urandom, lat, rd, ec, wc);
        idx = 0; nRsp = 0; cyc = 0;
        while (nRsp < 4 && cyc < 80) begin
            @(posedge clk); #1;
            reqValid[d] = (idx < 4); reqWe[d] = 1'b0; reqAddr[d] = AW'(10'h040 + idx); rspReady[d] = 1'b1;
            #1;
            if (ramEna[d]) enaCyc.push_back(cyc);
            if (rspValid[d]) begin
                expD = (expQ.size() > 0) ? expQ.pop_front() : 'x;
                total++; if (rspRdata[d] !== expD) begin bad++; $display("FAIL b2b_data[%0d] rsp%0d actual=%h required=%h", d, nRsp, rspRdata[d], expD); end
                nRsp++;
            end
            if (reqValid[d] && reqReady[d]) begin expQ.push_back(refMem[d][reqAddr[d]]); idx++; end
            cyc++;
        end
        reqValid[d] = 1'b0;
        total++; if (nRsp != 4 || enaCyc.size() != 4) begin bad++; $display("FAIL b2b_count[%0d] actual=rsp%0d/ena%0d required=4/4", d, nRsp, enaCyc.size()); end
        for (int i = 1; i < enaCyc.size(); i++) begin
            total++; if (enaCyc[i] - enaCyc[i-1] != d + 2) begin bad++; $display("FAIL b2b_gap[%0d] actual=%0d required=%0d", d, enaCyc[i] - enaCyc[i-1], d + 2); end
        end
    endtask

    task automatic test_random(input int d);
        int lat, ec, wc;
        logic [DW-1:0] rd, wd, expD;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic we;
        for (int n = 0; n < 40; n++) begin
            a  = AW'($urandom_range(16'h80, 16'h87));
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: be = '1;
                1: be = '0;
                default: be = BW'($urandom);
            endcase
            wd = $urandom;
            expD = we ? '0 : refMem[d][a];
            doReq(d, we, a, be, wd, lat, rd, ec, wc);
            total++; if (lat != expLat(d, we, be)) begin bad++; $display("FAIL rand_latency[%0d] n%0d we%b be%b actual=%0d required=%0d", d, n, we, be, lat, expLat(d, we, be)); end
            total++; if (rd !== expD) begin bad++; $display("FAIL rand_data[%0d] n%0d actual=%h required=%h", d, n, rd, expD); end
            total++; if (ec != expEna(we, be)) begin bad++; $display("FAIL rand_ena[%0d] n%0d actual=%0d required=%0d", d, n, ec, expEna(we, be)); end
        end
    endtask

    task automatic test_reset_mid_rmw(input int d);
        int lat, ec, wc;
        logic [DW-1:0] rd, pre;
        pre = $urandom;
        doReq(d, 1'b1, AW'(10'h030), '1, pre, lat, rd, ec, wc);
        @(posedge clk); #1;
        reqValid[d] = 1'b1; reqWe[d] = 1'b1; reqAddr[d] = AW'(10'h030); reqBe[d] = 4'b0011;
        reqWdata[d] = ~pre; rspReady[d] = 1'b1;
        #1;
        total++; if (reqReady[d] !== 1'b1 || ramEna[d] !== 1'b1 || ramWea[d] !== 1'b0) begin bad++; $display("FAIL rstmid_read_phase[%0d] actual=rdy%b/ena%b/wea%b required=1/1/0", d, reqReady[d], ramEna[d], ramWea[d]); end
        @(posedge clk); #1;
        reqValid[d] = 1'b0; rst_n = 1'b0;
        #1;
        total++; if (ramEna[d] !== 1'b0 || rspValid[d] !== 1'b0 || reqReady[d] !== 1'b0) begin bad++; $display("FAIL rstmid_in_reset[%0d] actual=ena%b/v%b/rdy%b required=0/0/0", d, ramEna[d], rspValid[d], reqReady[d]); end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        #1;
        total++; if (reqReady[d] !== 1'b1 || rspValid[d] !== 1'b0) begin bad++; $display("FAIL rstmid_release[%0d] actual=rdy%b/v%b required=1/0", d, reqReady[d], rspValid[d]); end
        @(posedge clk); #2;
        total++; if (rspValid[d] !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp[%0d] actual=%b required=0", d, rspValid[d]); end
        doReq(d, 1'b0, AW'(10'h030), '0, '0, lat, rd, ec, wc);
        total++; if (rd !== pre) begin bad++; $display("FAIL rstmid_mem_kept[%0d] actual=%h required=%h", d, rd, pre); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; memClear = 1'b1;
        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqAddr[d] = '0; reqBe[d] = '0;
            reqWdata[d] = '0; rspReady[d] = 1'b1;
            for (int i = 0; i < DEPTH; i++) refMem[d][i] = '0;
        end
        $display("[TB] start");
        test_reset();
        for (int d = 0; d < 2; d++) begin
            $display("[TB] RAM_LATENCY=%0d", d + 1);
            test_read_after_reset(d);
            test_full_write(d);
            test_partial_write(d);
            test_backpressure(d);
            test_back_to_back(d);
            test_random(d);
            test_reset_mid_rmw(d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
